// File: rtl/eth_tx_frame_fifo_pkg.sv
// ---------------------------------------------------------------------------
// eth_tx_fifo_pkg
// Shared widths, RAM entry layout and write-FSM state type for the
// eth_tx_frame_fifo store-and-forward buffer.
// ---------------------------------------------------------------------------
package eth_tx_fifo_pkg;

   localparam int DATA_W  = 64;
   localparam int KEEP_W  = 8;
   localparam int ENTRY_W = 73;

   // RAM entry layout: {tlast, tkeep[7:0], tdata[63:0]}
   localparam int ENT_DATA_LSB = 0;
   localparam int ENT_KEEP_LSB = 64;
   localparam int ENT_LAST_BIT = 72;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FRAME   = 2'd1,
      DISCARD = 2'd2
   } wr_state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic              last,
      input logic [KEEP_W-1:0] keep,
      input logic [DATA_W-1:0] data
   );
      return {last, keep, data};
   endfunction

endpackage

// File: rtl/eth_tx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_fifo_if
// 64-bit AXI-stream bundle used on both sides of the frame FIFO.
//   master: drives tvalid/tdata/tkeep/tlast/tuser, receives tready
//   slave : receives tvalid/tdata/tkeep/tlast/tuser, drives tready
// ---------------------------------------------------------------------------
interface eth_tx_frame_fifo_if;
   import eth_tx_fifo_pkg::*;

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic              tuser;

   modport master (
      output tvalid, tdata, tkeep, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tlast, tuser,
      output tready
   );

endinterface

// File: rtl/eth_tx_frame_fifo_ram.sv
// ---------------------------------------------------------------------------
// eth_tx_fifo_ram
// Simple dual-port RAM: one write port, one registered read port
// (read data valid the cycle after i_re). No reset on the array so it maps
// onto block RAM.
//   clk     : clock
//   i_we    : write enable, i_waddr / i_wdata
//   i_re    : read enable, i_raddr -> o_rdata one cycle later
// ---------------------------------------------------------------------------
module eth_tx_fifo_ram #(
   parameter int ADDR_W = 9,
   parameter int WIDTH  = 73
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_fifo
// Store-and-forward frame buffer feeding the 10G MAC transmit stream.
// A frame becomes visible to the read side only once its tlast beat is
// written without error, so the MAC sees gap-free tvalid within a frame.
// Bad frames (tuser on tlast) and frames that overflow are discarded.
//   clk156         : clock
//   sys_rst        : synchronous active-high reset
//   s_axis         : upstream stream (slave), never backpressures
//   eth_tx         : MAC transmit stream (master), tuser tied 0
//   drop_count     : discarded frames, saturating
//   tx_frame_count : frames fully accepted by the MAC, wrapping
// ---------------------------------------------------------------------------
module eth_tx_frame_fifo
   import eth_tx_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                clk156,
   input  logic                sys_rst,
   eth_tx_frame_fifo_if.slave  s_axis,
   eth_tx_frame_fifo_if.master eth_tx,
   output logic [15:0]         drop_count,
   output logic [31:0]         tx_frame_count
);

   localparam int                PTR_W = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0]  DEPTH = PTR_W'(2**ADDR_WIDTH);

   // ---------------- write side ----------------
   wr_state_t        r_wr_state;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_wr_commit;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_s_tready;
   logic [15:0]      r_drop_count;

   logic             w_beat;
   logic [PTR_W-1:0] w_used;
   logic             w_full;
   logic             w_we;
   logic             w_drop;

   assign w_beat = s_axis.tvalid & r_s_tready;
   assign w_used = r_wr_ptr - r_rd_ptr;
   assign w_full = (w_used == DEPTH);
   assign w_we   = w_beat && (r_wr_state != DISCARD) && !w_full;

   // A frame is lost when its tlast arrives while discarding, when the
   // tlast beat itself finds the buffer full, or when it is marked bad.
   assign w_drop = w_beat && s_axis.tlast &&
                   ((r_wr_state == DISCARD) || w_full || s_axis.tuser);

   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         r_wr_state  <= IDLE;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_s_tready  <= 1'b0;
      end else begin
         r_s_tready <= 1'b1;
         if (w_beat) begin
            case (r_wr_state)
               IDLE, FRAME: begin
                  if (w_full) begin
                     // Roll back the partial frame and ignore the rest.
                     r_wr_ptr   <= r_wr_commit;
                     r_wr_state <= s_axis.tlast ? IDLE : DISCARD;
                  end else if (s_axis.tlast && s_axis.tuser) begin
                     r_wr_ptr   <= r_wr_commit;
                     r_wr_state <= IDLE;
                  end else if (s_axis.tlast) begin
                     r_wr_ptr    <= r_wr_ptr + 1'b1;
                     r_wr_commit <= r_wr_ptr + 1'b1;
                     r_wr_state  <= IDLE;
                  end else begin
                     r_wr_ptr   <= r_wr_ptr + 1'b1;
                     r_wr_state <= FRAME;
                  end
               end
               DISCARD: begin
                  if (s_axis.tlast) begin
                     r_wr_state <= IDLE;
                  end
               end
               default: r_wr_state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 1'b1;
      end
   end

   // ---------------- storage ----------------
   logic             w_rd_issue;
   logic [ENTRY_W-1:0] w_ram_rdata;

   eth_tx_fifo_ram #(
      .ADDR_W (ADDR_WIDTH),
      .WIDTH  (ENTRY_W)
   ) u_ram (
      .clk     (clk156),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wdata (pack_entry(s_axis.tlast, s_axis.tkeep, s_axis.tdata)),
      .i_re    (w_rd_issue),
      .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rdata (w_ram_rdata)
   );

   // ---------------- read side ----------------
   // Two output slots; slot 0 drives the MAC directly. r_rd_vld marks a RAM
   // read in flight whose data lands in a slot on the next edge.
   logic               r_rd_vld;
   logic [1:0]         r_occ;
   logic [ENTRY_W-1:0] r_slot [2];
   logic [ENTRY_W-1:0] w_slot_next [2];
   logic [1:0]         w_occ_after;
   logic [1:0]         w_occ_next;
   logic [1:0]         w_level;
   logic               w_pop;
   logic [31:0]        r_tx_frame_count;

   assign w_pop   = (r_occ != 2'd0) && eth_tx.tready;
   assign w_level = r_occ + {1'b0, r_rd_vld};

   // Issue a read only if, after this cycle's pop, the slots plus the read
   // in flight still leave room for one more word. Counting the pop keeps a
   // one-word-per-cycle stream flowing while tready stays high.
   assign w_rd_issue = (r_rd_ptr != r_wr_commit) &&
                       ((w_level - {1'b0, w_pop}) < 2'd2);

   always_comb begin
      w_slot_next[0] = r_slot[0];
      w_slot_next[1] = r_slot[1];
      w_occ_after    = r_occ - {1'b0, w_pop};
      if (w_pop) begin
         w_slot_next[0] = r_slot[1];
      end
      if (r_rd_vld) begin
         if (w_occ_after == 2'd0) begin
            w_slot_next[0] = w_ram_rdata;
         end else begin
            w_slot_next[1] = w_ram_rdata;
         end
      end
      w_occ_next = w_occ_after + {1'b0, r_rd_vld};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         always_ff @(posedge clk156) begin
            if (sys_rst) begin
               r_slot[gi] <= '0;
            end else begin
               r_slot[gi] <= w_slot_next[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         r_rd_ptr         <= '0;
         r_rd_vld         <= 1'b0;
         r_occ            <= '0;
         r_tx_frame_count <= '0;
      end else begin
         r_rd_vld <= w_rd_issue;
         r_occ    <= w_occ_next;
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_pop && r_slot[0][ENT_LAST_BIT]) begin
            r_tx_frame_count <= r_tx_frame_count + 1'b1;
         end
      end
   end

   // ---------------- outputs ----------------
   assign s_axis.tready  = r_s_tready;
   assign eth_tx.tvalid  = (r_occ != 2'd0);
   assign eth_tx.tdata   = r_slot[0][ENT_DATA_LSB +: DATA_W];
   assign eth_tx.tkeep   = r_slot[0][ENT_KEEP_LSB +: KEEP_W];
   assign eth_tx.tlast   = r_slot[0][ENT_LAST_BIT];
   assign eth_tx.tuser   = 1'b0;
   assign drop_count     = r_drop_count;
   assign tx_frame_count = r_tx_frame_count;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_frame_fifo
// Directed and randomized frames against a frame-level reference model:
// a frame is expected at the MAC side iff it is good (tuser=0) and no longer
// than the buffer depth; otherwise it counts as one drop. The buffer is
// drained between frames so each frame starts against an empty buffer.
// ---------------------------------------------------------------------------
module tb_eth_tx_frame_fifo;
   import eth_tx_fifo_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] drop_count;
   logic [31:0] tx_cnt;

   always #5 clk = ~clk;

   eth_tx_frame_fifo_if s_if ();
   eth_tx_frame_fifo_if m_if ();

   eth_tx_frame_fifo #(.ADDR_WIDTH(AW)) dut (
      .clk156         (clk),
      .sys_rst        (rst),
      .s_axis         (s_if.slave),
      .eth_tx         (m_if.master),
      .drop_count     (drop_count),
      .tx_frame_count (tx_cnt)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t exp_q[$];
   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    exp_drops  = 0;
   int    exp_frames = 0;
   int    rdy_mode   = 1;
   int    hs_count   = 0;
   int    first_hs   = 0;
   int    last_hs    = 0;
   int    first_valid = -1;
   int    last_tlast_cyc = 0;
   bit    mon_en     = 1'b0;
   bit    in_frame   = 1'b0;
   bit    prev_stall = 1'b0;
   bit    prev_valid = 1'b0;
   beat_t prev_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      beat_t cur;
      beat_t e;
      cur = '{d: m_if.tdata, k: m_if.tkeep, l: m_if.tlast};
      if (m_if.tvalid === 1'b1 && !prev_valid && first_valid < 0) first_valid = cyc;
      if (in_frame) chk("tvalid_continuity", 64'(m_if.tvalid), 64'd1);
      if (prev_stall) begin
         chk("stall_hold_data", cur.d, prev_b.d);
         chk("stall_hold_keep", 64'(cur.k), 64'(prev_b.k));
         chk("stall_hold_last", 64'(cur.l), 64'(prev_b.l));
      end
      if (m_if.tvalid === 1'b1) chk("tx_tuser", 64'(m_if.tuser), 64'd0);
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         hs_count++;
         if (hs_count == 1) first_hs = cyc;
         last_hs = cyc;
         if (exp_q.size() == 0) begin
            chk("beat_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("tx_data", cur.d, e.d);
            chk("tx_keep", 64'(cur.k), 64'(e.k));
            chk("tx_last", 64'(cur.l), 64'(e.l));
            in_frame = !cur.l;
         end
      end
      prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
      prev_valid = (m_if.tvalid === 1'b1);
      prev_b     = cur;
   endtask

   // One clock cycle: inputs applied at the falling edge, outputs observed.
   task automatic tick(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
      @(negedge clk);
      cyc++;
      s_if.tvalid = v;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      s_if.tuser  = u;
      case (rdy_mode)
         0:       m_if.tready = 1'b0;
         2:       m_if.tready = cyc[0];
         3:       m_if.tready = 1'($urandom_range(0, 1));
         default: m_if.tready = 1'b1;
      endcase
      if (mon_en) monitor();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input int len, input logic [7:0] lastkeep, input logic user);
      beat_t fb[$];
      beat_t b;
      chk("s_tready_before_frame", 64'(s_if.tready), 64'd1);
      for (int i = 0; i < len; i++) begin
         b.d = {$urandom, $urandom};
         b.l = (i == len - 1);
         b.k = b.l ? lastkeep : 8'hFF;
         tick(1'b1, b.d, b.k, b.l, b.l ? user : 1'b0);
         fb.push_back(b);
      end
      last_tlast_cyc = cyc;
      tick(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
      if (len <= DEPTH && !user) begin
         foreach (fb[i]) exp_q.push_back(fb[i]);
         exp_frames++;
      end else begin
         exp_drops++;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_if.tvalid === 1'b1) && n < budget) begin
         idle(1);
         n++;
      end
      chk("drain_within_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic chk_counts();
      chk("drop_count", 64'(drop_count), 64'(exp_drops));
      chk("tx_frame_count", 64'(tx_cnt), 64'(exp_frames));
   endtask

   initial begin
      int n;
      int len;
      logic [7:0] full_keep;
      logic [7:0] k;
      logic u;

      full_keep   = 8'hFF;
      rst         = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      m_if.tready = 1'b0;

      // Reset state
      idle(2);
      chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_tdata", m_if.tdata, 64'd0);
      chk("rst_tkeep", 64'(m_if.tkeep), 64'd0);
      chk("rst_tlast", 64'(m_if.tlast), 64'd0);
      chk("rst_tuser", 64'(m_if.tuser), 64'd0);
      chk("rst_s_tready", 64'(s_if.tready), 64'd0);
      chk_counts();
      rst = 1'b0;
      idle(3);
      mon_en = 1'b1;

      // 8-beat frame, 60 bytes, latency tlast -> tvalid of 3 cycles
      rdy_mode = 1; hs_count = 0; first_valid = -1;
      send_frame(8, 8'h0F, 1'b0);
      drain(100);
      chk("latency_tlast_to_tvalid", 64'(first_valid - last_tlast_cyc), 64'd3);
      chk("single_frame_beats", 64'(hs_count), 64'd8);
      chk("single_frame_contiguous", 64'(last_hs - first_hs), 64'd7);
      chk_counts();

      // Same frame with tready toggling every cycle
      rdy_mode = 2; hs_count = 0;
      send_frame(8, 8'h0F, 1'b0);
      drain(100);
      chk("toggle_frame_beats", 64'(hs_count), 64'd8);
      chk_counts();

      // Bad frame followed by a good 2-beat frame
      rdy_mode = 1; hs_count = 0;
      send_frame(5, 8'hFF, 1'b1);
      send_frame(2, 8'h03, 1'b0);
      drain(100);
      chk("after_bad_beats", 64'(hs_count), 64'd2);
      chk_counts();

      // Overflow: 20-beat frame into 16-entry buffer, then exactly 16 beats
      rdy_mode = 0;
      send_frame(20, 8'hFF, 1'b0);
      idle(6);
      chk("overflow_tvalid_low", 64'(m_if.tvalid), 64'd0);
      chk_counts();
      send_frame(DEPTH, 8'h7F, 1'b0);
      idle(5);
      chk("full_frame_presented", 64'(m_if.tvalid), 64'd1);
      rdy_mode = 1; hs_count = 0;
      drain(100);
      chk("full_frame_beats", 64'(hs_count), 64'(DEPTH));
      chk_counts();

      // Three back-to-back 3-beat frames released into a ready MAC
      rdy_mode = 0;
      for (int f = 0; f < 3; f++) send_frame(3, 8'h01, 1'b0);
      idle(4);
      rdy_mode = 1; hs_count = 0;
      drain(100);
      chk("b2b_beats", 64'(hs_count), 64'd9);
      chk("b2b_no_bubble", 64'(last_hs - first_hs), 64'd8);
      chk_counts();

      // Reset in the middle of a 10-beat frame's output
      rdy_mode = 1; hs_count = 0;
      send_frame(10, 8'h3F, 1'b0);
      n = 0;
      while (hs_count < 3 && n < 50) begin
         idle(1);
         n++;
      end
      chk("reset_test_started", 64'(hs_count >= 3), 64'd1);
      mon_en = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("midrst_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("midrst_drop_count", 64'(drop_count), 64'd0);
      chk("midrst_tx_count", 64'(tx_cnt), 64'd0);
      exp_q.delete();
      exp_drops = 0; exp_frames = 0;
      in_frame = 1'b0; prev_stall = 1'b0; prev_valid = 1'b0;
      idle(3);
      mon_en = 1'b1;
      hs_count = 0;
      send_frame(10, 8'h3F, 1'b0);
      drain(100);
      chk("post_rst_frame_beats", 64'(hs_count), 64'd10);
      chk_counts();

      // Randomized frames: lengths around the depth boundary, random tuser,
      // random tail keep and random MAC backpressure
      for (int f = 0; f < 14; f++) begin
         len = $urandom_range(1, DEPTH + 4);
         u   = ($urandom_range(0, 5) == 0);
         k   = full_keep >> $urandom_range(0, 7);
         rdy_mode = $urandom_range(1, 3);
         send_frame(len, k, u);
         drain(400);
      end
      chk_counts();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
